// File: rtl/rom_read_sequencer.sv
// Sequences a complete read of a parallel ROM from address 0 to LAST_ADDR,
// with a programmable output-enable access time and a valid/ready byte handoff.
module rom_read_sequencer #(
    parameter int unsigned ADDR_WIDTH    = 9,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ACCESS_CYCLES = 8,
    parameter int unsigned LAST_ADDR     = 511
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  step_mode,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [ADDR_WIDTH-1:0] rom_address,
    output logic                  rom_cs_n,
    output logic                  rom_oe_n,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_HANDOFF,
        S_ADVANCE,
        S_WAIT_STEP,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST     = ADDR_WIDTH'(LAST_ADDR);
    localparam logic [7:0]            CNT_LOAD = 8'(ACCESS_CYCLES - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [7:0]            cnt_q,   cnt_d;
    logic [DATA_WIDTH-1:0] data_q,  data_d;
    logic                  valid_q, valid_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    addr_d  = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d   = CNT_LOAD;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                // Counter runs ACCESS_CYCLES-1 down to 0; capture on the final cycle.
                if (cnt_q == '0) begin
                    data_d  = rom_data;
                    valid_d = 1'b1;
                    state_d = S_HANDOFF;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_HANDOFF: begin
                if (valid_q && data_ready) begin
                    valid_d = 1'b0;
                    state_d = S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if (addr_q == LAST) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = step_mode ? S_WAIT_STEP : S_SETUP;
                end
            end
            S_WAIT_STEP: begin
                if (step) begin
                    state_d = S_SETUP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rom_address = addr_q;
    assign rom_cs_n    = !((state_q == S_SETUP) || (state_q == S_ACCESS));
    assign rom_oe_n    = (state_q != S_ACCESS);
    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_rom_read_sequencer.sv
// Bench for rom_read_sequencer: a full-size scan instance and a short fast-access
// instance, both fed by a ROM model that only returns true data after the access time.
module tb_rom_read_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A: defaults (N=8, 512 addresses)
    logic       start_a, step_mode_a, step_a, ready_a;
    logic [7:0] rom_data_a, dout_a;
    logic [8:0] addr_a;
    logic       cs_n_a, oe_n_a, dv_a, busy_a, done_a;

    // Instance B: N=1, addresses 0..3
    logic       start_b, step_mode_b, step_b, ready_b;
    logic [7:0] rom_data_b, dout_b;
    logic [8:0] addr_b;
    logic       cs_n_b, oe_n_b, dv_b, busy_b, done_b;

    rom_read_sequencer #(.ADDR_WIDTH(9), .DATA_WIDTH(8), .ACCESS_CYCLES(8), .LAST_ADDR(511)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .step_mode(step_mode_a), .step(step_a),
        .rom_data(rom_data_a), .rom_address(addr_a), .rom_cs_n(cs_n_a), .rom_oe_n(oe_n_a),
        .data_out(dout_a), .data_valid(dv_a), .data_ready(ready_a), .busy(busy_a), .done(done_a)
    );

    rom_read_sequencer #(.ADDR_WIDTH(9), .DATA_WIDTH(8), .ACCESS_CYCLES(1), .LAST_ADDR(3)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .step_mode(step_mode_b), .step(step_b),
        .rom_data(rom_data_b), .rom_address(addr_b), .rom_cs_n(cs_n_b), .rom_oe_n(oe_n_b),
        .data_out(dout_b), .data_valid(dv_b), .data_ready(ready_b), .busy(busy_b), .done(done_b)
    );

    // ROM model: inverted (wrong) data until OE has been low for the full access time.
    logic [7:0] mem_a [512];
    logic [7:0] mem_b [4];
    int oe_run_a = 0;
    always @(posedge clk) oe_run_a <= oe_n_a ? 0 : oe_run_a + 1;
    assign rom_data_a = (!oe_n_a && !cs_n_a && oe_run_a >= 7) ? mem_a[addr_a] : ~mem_a[addr_a];
    assign rom_data_b = (!oe_n_b && !cs_n_b) ? mem_b[addr_b[1:0]] : ~mem_b[addr_b[1:0]];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_a, nhs_a, oecnt_a, stall_a;
    int exp_b, nhs_b, oecnt_b, stall_b;
    int hs_cyc_b [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_a();
        exp_a = 0; nhs_a = 0; oecnt_a = 0; stall_a = 0;
    endtask

    task automatic clr_b();
        exp_b = 0; nhs_b = 0; oecnt_b = 0; stall_b = 0; hs_cyc_b.delete();
    endtask

    // Advance one clock; check handshakes and stall behaviour seen at that edge.
    task automatic tick();
        logic       hs_a, st_a, hs_b, st_b, rst;
        logic [7:0] d_a, d_b;
        logic [8:0] ad_a, ad_b;
        rst  = reset;
        hs_a = dv_a && ready_a;  st_a = dv_a && !ready_a;  d_a = dout_a;  ad_a = addr_a;
        hs_b = dv_b && ready_b;  st_b = dv_b && !ready_b;  d_b = dout_b;  ad_b = addr_b;
        if (!oe_n_a) oecnt_a++;
        if (!oe_n_b) oecnt_b++;
        @(posedge clk);
        #1;
        cyc++;
        if (!rst && st_a) begin
            stall_a++;
            chk("stall_valid", dv_a, 1);
            chk("stall_data", dout_a, d_a);
            chk("stall_addr", addr_a, ad_a);
            chk("stall_cs_n", cs_n_a, 1);
            chk("stall_oe_n", oe_n_a, 1);
        end
        if (!rst && hs_a) begin
            chk("hs_addr_a", ad_a, exp_a);
            chk("hs_data_a", d_a, mem_a[exp_a]);
            chk("hs_oe_cycles_a", oecnt_a, 8);
            exp_a++; nhs_a++; oecnt_a = 0;
        end
        if (!rst && st_b) begin
            stall_b++;
            chk("stall_data_b", dout_b, d_b);
            chk("stall_valid_b", dv_b, 1);
        end
        if (!rst && hs_b) begin
            chk("hs_addr_b", ad_b, exp_b);
            chk("hs_data_b", d_b, mem_b[exp_b]);
            chk("hs_oe_cycles_b", oecnt_b, 1);
            hs_cyc_b.push_back(cyc);
            exp_b++; nhs_b++; oecnt_b = 0;
        end
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_addr"},  addr_a, 0);
        chk({tag, "_cs_n"},  cs_n_a, 1);
        chk({tag, "_oe_n"},  oe_n_a, 1);
        chk({tag, "_dout"},  dout_a, 0);
        chk({tag, "_valid"}, dv_a, 0);
        chk({tag, "_busy"},  busy_a, 0);
        chk({tag, "_done"},  done_a, 0);
    endtask

    initial begin
        int t0, budget;
        reset = 1'b1;
        start_a = 0; step_mode_a = 0; step_a = 0; ready_a = 1;
        start_b = 0; step_mode_b = 0; step_b = 0; ready_b = 1;
        for (int i = 0; i < 512; i++) mem_a[i] = 8'(i) ^ 8'hA5;
        for (int i = 0; i < 4; i++) mem_b[i] = 8'($urandom);
        clr_a(); clr_b();

        // Reset values
        repeat (3) tick();
        chk_reset_a("rst_a");
        chk("rst_b_busy", busy_b, 0);
        chk("rst_b_done", done_b, 0);
        reset = 1'b0;
        tick();

        // Full scan, ready held high, data = addr ^ A5
        start_a = 1; tick(); start_a = 0;
        t0 = cyc;
        chk("t1_setup_busy", busy_a, 1);
        chk("t1_setup_cs_n", cs_n_a, 0);
        chk("t1_setup_oe_n", oe_n_a, 1);
        chk("t1_setup_addr", addr_a, 0);
        budget = 0;
        while (!done_a && budget < 20000) begin tick(); budget++; end
        chk("t1_done", done_a, 1);
        chk("t1_cycles", cyc - t0, 5632);
        chk("t1_handshakes", nhs_a, 512);
        chk("t1_last_addr", addr_a, 511);
        chk("t1_busy", busy_a, 0);
        repeat (4) tick();
        chk("t1_done_held", done_a, 1);
        chk("t1_addr_held", addr_a, 511);

        // Restart from DONE with random data and a 5-cycle stall at address 10
        for (int i = 0; i < 512; i++) mem_a[i] = 8'($urandom);
        clr_a();
        start_a = 1; tick(); start_a = 0;
        t0 = cyc;
        chk("t2_done_cleared", done_a, 0);
        chk("t2_restart_addr", addr_a, 0);
        chk("t2_busy", busy_a, 1);
        budget = 0;
        begin
            int stall_left = 5;
            while (!done_a && budget < 20000) begin
                if (addr_a == 9'd10 && dv_a && stall_left > 0) begin
                    ready_a = 0; stall_left--;
                end else begin
                    ready_a = 1;
                end
                tick(); budget++;
            end
        end
        ready_a = 1;
        chk("t2_done", done_a, 1);
        chk("t2_stall_count", stall_a, 5);
        chk("t2_cycles", cyc - t0, 5637);
        chk("t2_handshakes", nhs_a, 512);

        // Single-step mode
        for (int i = 0; i < 512; i++) mem_a[i] = 8'($urandom);
        clr_a();
        step_mode_a = 1;
        start_a = 1; tick(); start_a = 0;
        budget = 0;
        while (nhs_a < 1 && budget < 100) begin tick(); budget++; end
        repeat (3) tick();
        chk("t3_first_hs", nhs_a, 1);
        chk("t3_wait_addr", addr_a, 1);
        chk("t3_wait_busy", busy_a, 1);
        chk("t3_wait_cs_n", cs_n_a, 1);
        chk("t3_wait_oe_n", oe_n_a, 1);
        start_a = 1; tick(); start_a = 0;
        repeat (30) tick();
        chk("t3_start_ignored_hs", nhs_a, 1);
        chk("t3_start_ignored_addr", addr_a, 1);
        for (int k = 1; k <= 3; k++) begin
            step_a = 1; tick(); step_a = 0;
            repeat (30) tick();
            chk("t3_step_hs", nhs_a, k + 1);
            chk("t3_step_addr", addr_a, k + 1);
        end
        step_mode_a = 0;
        step_a = 1; tick(); step_a = 0;
        budget = 0;
        while (!done_a && budget < 20000) begin tick(); budget++; end
        chk("t3_done", done_a, 1);
        chk("t3_handshakes", nhs_a, 512);

        // Start while busy ignored; reset during ACCESS at address 100
        clr_a();
        start_a = 1; tick(); start_a = 0;
        budget = 0;
        while (!(addr_a == 9'd50 && !oe_n_a) && budget < 2000) begin tick(); budget++; end
        start_a = 1; tick(); start_a = 0;
        chk("t4_busy_start_addr", addr_a, 50);
        chk("t4_busy_start_busy", busy_a, 1);
        budget = 0;
        while (!(addr_a == 9'd100 && !oe_n_a) && budget < 2000) begin tick(); budget++; end
        chk("t4_reached_100", addr_a, 100);
        reset = 1; start_a = 1; tick(); reset = 0; start_a = 0;
        chk_reset_a("t4_midscan_rst");
        clr_a();
        repeat (2) tick();
        chk("t4_idle_after_rst", busy_a, 0);
        start_a = 1; tick(); start_a = 0;
        t0 = cyc;
        chk("t4_rescan_addr", addr_a, 0);
        budget = 0;
        while (!done_a && budget < 20000) begin tick(); budget++; end
        chk("t4_cycles", cyc - t0, 5632);
        chk("t4_handshakes", nhs_a, 512);

        // Short instance: ACCESS_CYCLES=1, LAST_ADDR=3
        start_b = 1; tick(); start_b = 0;
        t0 = cyc;
        budget = 0;
        while (!done_b && budget < 200) begin tick(); budget++; end
        chk("b1_cycles", cyc - t0, 16);
        chk("b1_handshakes", nhs_b, 4);
        chk("b1_last_addr", addr_b, 3);
        for (int i = 1; i < hs_cyc_b.size(); i++)
            chk("b1_byte_period", hs_cyc_b[i] - hs_cyc_b[i-1], 4);

        // Short instance with random backpressure
        for (int i = 0; i < 4; i++) mem_b[i] = 8'($urandom);
        clr_b();
        start_b = 1; tick(); start_b = 0;
        t0 = cyc;
        budget = 0;
        while (!done_b && budget < 1000) begin
            ready_b = 1'($urandom_range(0, 1));
            tick(); budget++;
        end
        ready_b = 1;
        chk("b2_done", done_b, 1);
        chk("b2_handshakes", nhs_b, 4);
        chk("b2_cycles", cyc - t0, 16 + stall_b);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_read_sequencer.md
# rom_read_sequencer

Controller that sequences a full read of the parallel ROM under test. It steps the ROM address from 0 to LAST_ADDR and drives chip-select and output-enable with a programmable access time. Each captured byte is handed downstream (UART/packetiser) over a valid/ready handshake. The current address bus also feeds the 3-digit address display, so the operator sees the scan position; single-step mode is provided for manual probing.

## Interface
- ADDR_WIDTH, 9, width of ROM address bus (matches display input)
- DATA_WIDTH, 8, ROM data width
- ACCESS_CYCLES, 8, clocks OE is held low before data is sampled; legal range 1..255
- LAST_ADDR, 511, final address of a scan; must be < 2^ADDR_WIDTH
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a scan from address 0
- step_mode  in  1  1 = pause after every byte until `step`
- step  in  1  one-cycle pulse; advances one byte when paused
- rom_data  in  DATA_WIDTH  ROM data pins
- rom_address  out  ADDR_WIDTH  ROM address pins and display address_line
- rom_cs_n  out  1  ROM chip select, active-low
- rom_oe_n  out  1  ROM output enable, active-low
- data_out  out  DATA_WIDTH  captured byte
- data_valid  out  1  data_out valid to downstream
- data_ready  in  1  downstream accepts data_out
- busy  out  1  scan in progress (any state except IDLE/DONE)
- done  out  1  scan complete; held until start or reset

## Operation
- States: IDLE, SETUP, ACCESS, HANDOFF, ADVANCE, WAIT_STEP, DONE.
- IDLE: rom_cs_n=1, rom_oe_n=1. Sampling start=1 loads rom_address=0 and goes to SETUP.
- SETUP (1 cycle): rom_cs_n=0, rom_oe_n=1, address stable. Goes to ACCESS and loads the access counter.
- ACCESS (exactly ACCESS_CYCLES cycles): rom_cs_n=0, rom_oe_n=0.
  - At the clock edge ending the last ACCESS cycle, rom_data is registered into data_out, data_valid is set, and the state goes to HANDOFF.
- HANDOFF: rom_cs_n=1, rom_oe_n=1, data_valid=1. data_out is held stable.
  - When data_valid && data_ready is sampled, data_valid clears and the state goes to ADVANCE.
- ADVANCE (1 cycle):
  - If rom_address==LAST_ADDR, go to DONE; the address is not incremented and there is no wrap.
  - Otherwise rom_address+1. Then go to WAIT_STEP if step_mode=1, else to SETUP.
- WAIT_STEP: ROM deselected, address holds the next address. step=1 goes to SETUP.
- DONE: done=1, rom_address holds LAST_ADDR. start=1 clears done, loads address 0 and goes to SETUP.
- start is ignored in every state except IDLE and DONE. step is ignored except in WAIT_STEP.
- step_mode is sampled only in ADVANCE, so changing it mid-byte takes effect at the next byte boundary.
- Address arithmetic is unsigned ADDR_WIDTH; the increment never overflows because of the LAST_ADDR check.

## Timing
- Reset values: rom_address=0, rom_cs_n=1, rom_oe_n=1, data_out=0, data_valid=0, busy=0, done=0, state=IDLE.
- Reset asserted mid-scan returns to these values on the next edge and abandons the byte in flight. Reset wins over start/step in the same cycle.
- Start sampled at edge k gives SETUP during cycle k+1, with busy=1 from cycle k+1.
- Per-byte period with data_ready held 1 and step_mode=0 is ACCESS_CYCLES+3 clocks: SETUP 1 + ACCESS N + HANDOFF 1 + ADVANCE 1.
- Full scan = (LAST_ADDR+1)·(ACCESS_CYCLES+3) clocks from first SETUP to done=1. Defaults give 512·11 = 5632.
- Each data_ready=0 cycle in HANDOFF adds one clock. data_out/data_valid must not change while stalled.
- data_valid rises in the first HANDOFF cycle. rom_oe_n deasserts in that same cycle, with the data already registered.

## Test plan
- Reset, then start with ROM model data=addr[7:0]^8'hA5, ready=1 -> 512 handshakes with data 8'hA5, 8'hA4, …, last (addr 511) 8'h5A; done=1 exactly 5632 clocks after the first SETUP; rom_address=511.
- ACCESS_CYCLES=1, LAST_ADDR=3 -> bytes every 4 clocks; rom_oe_n low exactly 1 cycle per byte; done after 16 clocks.
- Backpressure: ready low for 5 cycles at address 10 -> data_valid held, data_out unchanged, rom_cs_n/rom_oe_n high, rom_address=10 throughout; the scan completes 5 clocks late.
- step_mode=1 -> after byte 0, rom_address=1 and state idles in WAIT_STEP; a start pulse has no effect; each step pulse yields exactly one more handshake.
- Reset asserted during ACCESS at address 100 -> next cycle all outputs are at reset values; a subsequent start rescans from address 0.
- Start pulse while busy is ignored; start in DONE clears done and restarts at 0.
